// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the imem req/ack handshake and
// buffers one word for decode. Optional MISALIGN_TRAP_EN adds a sticky misaligned trap.
module fetch_ctrl #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              stall,
  input  logic              b_out,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
`ifdef MISALIGN_TRAP_EN
  output logic              misaligned,
`endif
  output logic              flush
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DROP} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_bad;
  logic              halted;
  logic              redirect, accept, ack_ok;
  logic              load_word, clr_valid;

`ifdef MISALIGN_TRAP_EN
  logic misal_q;
  assign tgt      = target;
  assign tgt_bad  = (target[1:0] != 2'b00);
  assign halted   = misal_q;
  assign misaligned = misal_q;
`else
  assign tgt      = target & ~ADDR_W'(3);
  assign tgt_bad  = 1'b0;
  assign halted   = 1'b0;
`endif

  assign redirect = b_out | jump;
  // Once trapped, further redirects are not accepted; the pipeline stays empty.
  assign accept   = redirect && (state_q != S_BOOT) && !halted;
  assign ack_ok   = imem_ack && imem_req;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    load_word = 1'b0;
    clr_valid = 1'b0;
    imem_req  = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = !halted;
        if (accept) begin
          clr_valid = 1'b1;
          pc_d      = tgt_bad ? pc_q : tgt;
          state_d   = ack_ok ? S_FETCH : S_DROP;
        end else if (ack_ok) begin
          load_word = 1'b1;
          pc_d      = pc_q + ADDR_W'(4);
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (accept) begin
          clr_valid = 1'b1;
          pc_d      = tgt_bad ? pc_q : tgt;
          state_d   = S_FETCH;
        end else if (!stall) begin
          clr_valid = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_DROP: begin
        // Outstanding request must complete even after a trap.
        imem_req = 1'b1;
        if (accept) begin
          clr_valid = 1'b1;
          pc_d      = tgt_bad ? pc_q : tgt;
          state_d   = ack_ok ? S_FETCH : S_DROP;
        end else if (ack_ok) begin
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign imem_addr = addr_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
      pc_out      <= RESET_PC;
      flush       <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      // Address only moves when entering/staying in FETCH, i.e. req low or ack cycle.
      if (state_d == S_FETCH) addr_q <= pc_d;
      flush <= accept;
      if (load_word) begin
        instr       <= imem_rdata;
        pc_out      <= pc_q;
        instr_valid <= 1'b1;
      end else if (clr_valid) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)                  misal_q <= 1'b0;
    else if (accept && tgt_bad) misal_q <= 1'b1;
  end
`endif

endmodule
